// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: streams RGB444 pixels from framebuffer memory into a
// prefetch FIFO and pops one pixel per PIX_REQ for the VGA timing driver.
// Linear raster-order addressing, restarted at 0 on FRAME_START.
// Optional feature macro: VGA_FETCH_UFLOW_CNT_EN adds a saturating
// UFLOW_COUNT[15:0] output counting PIX_UNDERFLOW pulses.
module vga_pixel_fetch #(
    parameter int unsigned H_VISIBLE_AREA  = 800,
    parameter int unsigned V_VISIBLE_AREA  = 600,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_WIDTH      = 19
) (
    input  logic                  VGA_CLK,
    input  logic                  VGA_RST_N,
    input  logic                  FRAME_START,
    input  logic                  PIX_REQ,
    output logic [11:0]           PIX_RGB,
    output logic                  PIX_VALID,
    output logic                  PIX_UNDERFLOW,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_RD,
    input  logic                  MEM_WAIT,
    input  logic [11:0]           MEM_RDATA,
    input  logic                  MEM_RVALID
`ifdef VGA_FETCH_UFLOW_CNT_EN
    ,
    output logic [15:0]           UFLOW_COUNT
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(H_VISIBLE_AREA * V_VISIBLE_AREA - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DONE,
        ST_FLUSH
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [11:0]           r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [PTR_W:0]        w_count_nxt;
    logic [OUT_W-1:0]      r_outst;
    logic [OUT_W-1:0]      w_outst_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rd;
    logic [11:0]           r_rgb;
    logic                  r_valid;
    logic                  r_uflow;

    logic                  w_accept;
    logic                  w_last_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_uflow_evt;
    logic                  w_issue;

    assign w_accept      = r_rd & ~MEM_WAIT;
    assign w_last_accept = w_accept & (r_addr == LAST_ADDR);
    // Returns during FLUSH belong to the previous frame and are dropped.
    assign w_push        = MEM_RVALID & ((r_state == ST_FETCH) | (r_state == ST_DONE)) & ~FRAME_START;
    assign w_pop         = PIX_REQ & (r_count != '0) & ~FRAME_START;
    assign w_uflow_evt   = PIX_REQ & (r_count == '0) & ~FRAME_START;

    // Outstanding-read and FIFO-occupancy values after this cycle.
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_accept && !MEM_RVALID) begin
            w_outst_nxt = r_outst + 1'b1;
        end else if (!w_accept && MEM_RVALID && (r_outst != '0)) begin
            w_outst_nxt = r_outst - 1'b1;
        end

        w_count_nxt = r_count;
        if (FRAME_START) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Next-state and read-issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        if (FRAME_START) begin
            w_state_nxt = (w_outst_nxt == '0) ? ST_FETCH : ST_FLUSH;
        end else begin
            case (r_state)
                ST_FETCH: if (w_last_accept)       w_state_nxt = ST_DONE;
                ST_FLUSH: if (w_outst_nxt == '0)   w_state_nxt = ST_FETCH;
                default:                           w_state_nxt = r_state;
            endcase
        end
        // Credits are judged on post-update counts so a request raised now
        // always has a FIFO slot and an outstanding slot once accepted.
        if ((w_state_nxt == ST_FETCH) && !FRAME_START &&
            ((32'(w_count_nxt) + 32'(w_outst_nxt)) < FIFO_DEPTH) &&
            (32'(w_outst_nxt) < MAX_OUTSTANDING)) begin
            w_issue = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outstanding count and read request/address; request held while stalled.
    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            r_outst <= '0;
            r_addr  <= '0;
            r_rd    <= 1'b0;
        end else begin
            r_outst <= w_outst_nxt;
            if (FRAME_START) begin
                r_addr <= '0;
                r_rd   <= 1'b0;
            end else begin
                if (w_accept && (r_addr != LAST_ADDR)) begin
                    r_addr <= r_addr + 1'b1;
                end
                if (!r_rd || w_accept) begin
                    r_rd <= w_issue;
                end
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (FRAME_START) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge VGA_CLK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= MEM_RDATA;
        end
    end

    // Pixel response one cycle after PIX_REQ; RGB holds when idle.
    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            r_rgb   <= '0;
            r_valid <= 1'b0;
            r_uflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_uflow <= 1'b0;
            if (PIX_REQ) begin
                if (w_pop) begin
                    r_rgb   <= r_fifo[r_rd_ptr];
                    r_valid <= 1'b1;
                end else begin
                    r_rgb   <= '0;
                    r_uflow <= ~FRAME_START;
                end
            end
        end
    end

`ifdef VGA_FETCH_UFLOW_CNT_EN
    logic [15:0] r_uflow_cnt;

    // Saturating underflow count; only reset clears it.
    always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            r_uflow_cnt <= '0;
        end else if (w_uflow_evt && (r_uflow_cnt != '1)) begin
            r_uflow_cnt <= r_uflow_cnt + 1'b1;
        end
    end

    assign UFLOW_COUNT = r_uflow_cnt;
`else
    logic w_uflow_unused;
    assign w_uflow_unused = w_uflow_evt;
`endif

    assign PIX_RGB       = r_rgb;
    assign PIX_VALID     = r_valid;
    assign PIX_UNDERFLOW = r_uflow;
    assign MEM_ADDR      = r_addr;
    assign MEM_RD        = r_rd;

endmodule
